// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// The arbiter FSM is either free-running round-robin or locked to one owner.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int DEFAULT_MAX_BURST  = 4;

  // Burst counter must be able to hold the value max_burst itself.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int DEFAULT_BURST_CNT_W = burst_cnt_w(DEFAULT_MAX_BURST);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first asserted request
// searching upward from last_idx+1, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO among NUM_REQ producers,
// with bounded burst locking and a space guard that prevents FIFO overflow.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_almostfull,
  input  logic                            fifo_overflow,
  output logic                            ovf_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = burst_cnt_w(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_q, burst_d;

  logic [NUM_REQ-1:0]    pick;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  can_accept;
  logic                  accept;
  logic [IDX_W-1:0]      win_idx;
  logic [FIFO_WIDTH-1:0] win_data;

  // A registered write still in flight counts against the last free slot.
  assign can_accept = !fifo_full && !(fifo_almostfull && fifo_wr_en);

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req        (req),
    .last_idx   (last_gnt_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    last_gnt_d = last_gnt_q;
    gnt        = '0;
    win_idx    = pick_idx;
    accept     = 1'b0;

    if (!rst && can_accept) begin
      if (state_q == LOCKED && req[owner_q]) begin
        gnt[owner_q] = 1'b1;
        win_idx      = owner_q;
        accept       = 1'b1;
        if (!req_lock[owner_q] || burst_q >= CNT_W'(MAX_BURST - 1)) begin
          state_d = IDLE;
          burst_d = '0;
        end else begin
          burst_d = burst_q + CNT_W'(1);
        end
      end else begin
        // Either idle or the owner walked away: plain round-robin this cycle.
        state_d = IDLE;
        burst_d = '0;
        if (pick_valid) begin
          gnt        = pick;
          win_idx    = pick_idx;
          accept     = 1'b1;
          last_gnt_d = pick_idx;
          if (req_lock[pick_idx] && MAX_BURST > 1) begin
            state_d = LOCKED;
            owner_d = pick_idx;
            burst_d = CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_gnt_q   <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      burst_q      <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      ovf_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_data_in <= win_data;
      end
      ovf_err <= ovf_err | fifo_overflow;
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_has_req : assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == '0);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int DEPTH      = 8;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_overflow;
  logic                          ovf_err;

  bit model_fifo;
  bit full_drv, afull_drv, ovf_inject, rd, ovf_model;
  int cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  int              m_last;
  bit              m_locked;
  int              m_owner;
  int              m_beats;
  bit              m_wr;
  logic [FIFO_WIDTH-1:0] m_data;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    bit                 full;
    bit                 afull;
    logic [NUM_REQ-1:0] exp_gnt;
    bit                 exp_wr;
  } vec_t;

  vec_t tbl[13];

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_WIDTH (FIFO_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_lock        (req_lock),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_overflow   (fifo_overflow),
    .ovf_err         (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_full       = model_fifo ? (cnt == DEPTH)     : full_drv;
  assign fifo_almostfull = model_fifo ? (cnt == DEPTH - 1) : afull_drv;
  assign fifo_overflow   = ovf_inject | ovf_model;

  // Simple FIFO occupancy model driving the flags in model mode.
  always @(posedge clk) begin
    if (rst) begin
      cnt       <= 0;
      ovf_model <= 1'b0;
    end else begin
      ovf_model <= fifo_wr_en && (cnt == DEPTH) && !rd;
      cnt <= cnt - ((rd && cnt > 0) ? 1 : 0)
                 + ((fifo_wr_en && (cnt < DEPTH || rd)) ? 1 : 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                               input bit f, input bit af);
    req       = r;
    req_lock  = l;
    full_drv  = f;
    afull_drv = af;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    m_last   = NUM_REQ - 1;
    m_locked = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_wr     = 1'b0;
    m_data   = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    modelReset();
  endtask

  // Decide this cycle's winner from the rules, then advance the model.
  task automatic modelCycle(output logic [NUM_REQ-1:0] eg);
    bit can;
    int win;
    win = -1;
    eg  = '0;
    can = !rst && !fifo_full && !(fifo_almostfull && m_wr);
    if (can) begin
      if (m_locked && req[m_owner]) begin
        win = m_owner;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c = (m_last + k) % NUM_REQ;
          if (win < 0 && req[c]) win = c;
        end
      end
      if (win >= 0) begin
        if (m_locked && win == m_owner) begin
          m_beats++;
          if (!req_lock[win] || m_beats >= MAX_BURST) m_locked = 1'b0;
        end else begin
          m_locked = req_lock[win] && (MAX_BURST > 1);
          m_owner  = win;
          m_beats  = 1;
        end
        m_last = win;
      end else begin
        m_locked = 1'b0;
      end
    end
    if (win >= 0) begin
      eg[win] = 1'b1;
      m_data  = req_data[win*FIFO_WIDTH +: FIFO_WIDTH];
    end
    m_wr = (win >= 0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] eg;
    logic [NUM_REQ-1:0] seq_exp[6];
    int writes, grants;

    tbl[0]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1};
    tbl[2]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[3]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
    tbl[5]  = '{4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0};
    tbl[7]  = '{4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1};
    tbl[8]  = '{4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0};
    tbl[9]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[10] = '{4'b1111, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[11] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[12] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1};

    model_fifo = 1'b0;
    ovf_inject = 1'b0;
    rd         = 1'b0;
    req_data   = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    rst        = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("reset_data", 32'(fifo_data_in), 32'd0);
    checkOutput("reset_ovf_err", 32'(ovf_err), 32'd0);
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].req, tbl[i].lock, tbl[i].full, tbl[i].afull);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
      checkOutput($sformatf("tbl%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].exp_wr));
      nextCycle();
    end

    $display("[TB] burst lock on requester 2");
    doReset();
    seq_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      if (i == 0) applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
      else        applyStimulus(4'b1111, 4'b0100, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("burst%0d_gnt", i), 32'(gnt), 32'(seq_exp[i]));
      if (i > 0) checkOutput($sformatf("burst%0d_wr_en", i), 32'(fifo_wr_en), 32'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("burst_data", 32'(fifo_data_in), 32'h0000);

    $display("[TB] lock owner drops request");
    doReset();
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_first_gnt", 32'(gnt), 32'b0010);
    nextCycle();
    applyStimulus(4'b1010, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_locked_gnt", 32'(gnt), 32'b0010);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_release_gnt", 32'(gnt), 32'b1000);
    nextCycle();
    applyStimulus(4'b1010, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_after_gnt", 32'(gnt), 32'b0010);
    nextCycle();

    $display("[TB] reset during locked burst");
    doReset();
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(4'b1111, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rstlock_pre_gnt", 32'(gnt), 32'b0001);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("rstlock_gnt", 32'(gnt), 32'd0);
    checkOutput("rstlock_wr_en", 32'(fifo_wr_en), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rstlock_restart_gnt", 32'(gnt), 32'b0001);
    nextCycle();

    $display("[TB] sticky overflow error");
    doReset();
    ovf_inject = 1'b1;
    nextCycle();
    ovf_inject = 1'b0;
    @(negedge clk);
    checkOutput("ovf_set", 32'(ovf_err), 32'd1);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("ovf_sticky", 32'(ovf_err), 32'd1);
    doReset();
    @(negedge clk);
    checkOutput("ovf_cleared", 32'(ovf_err), 32'd0);

    $display("[TB] fill FIFO of depth %0d without reads", DEPTH);
    model_fifo = 1'b1;
    doReset();
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      nextCycle();
    end
    @(negedge clk);
    checkOutput("fill_writes", 32'(writes), 32'd8);
    checkOutput("fill_gnt_stalled", 32'(gnt), 32'd0);
    checkOutput("fill_count", 32'(cnt), 32'd8);
    checkOutput("fill_ovf_err", 32'(ovf_err), 32'd0);

    nextCycle();
    rd = 1'b1;
    writes = 0;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt != '0) grants++;
      if (fifo_wr_en) writes++;
      nextCycle();
      rd = 1'b0;
    end
    checkOutput("read_grants", 32'(grants), 32'd1);
    checkOutput("read_writes", 32'(writes), 32'd1);
    checkOutput("read_count", 32'(cnt), 32'd8);

    $display("[TB] randomized run against reference model");
    doReset();
    for (int i = 0; i < 500; i++) begin
      req      = NUM_REQ'($urandom);
      req_lock = NUM_REQ'($urandom & $urandom);
      req_data = {$urandom, $urandom};
      rd       = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checkOutput("rand_wr_en", 32'(fifo_wr_en), 32'(m_wr));
      checkOutput("rand_data", 32'(fifo_data_in), 32'(m_data));
      modelCycle(eg);
      checkOutput("rand_gnt", 32'(gnt), 32'(eg));
      nextCycle();
    end
    rd = 1'b0;
    @(negedge clk);
    checkOutput("rand_ovf_err", 32'(ovf_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
